// File: rtl/snoop_bus_n.sv
// rtl/snoop_bus_n.sv - round-robin MSI snooping coherence bus for NUM_CORES cores
//
// Arbitrates per-core read/write misses, broadcasts the winning address as a
// snoop, then sequences dirty-owner writeback, invalidation and completion.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   read_miss        per-core read-miss request (level)
//   write_miss       per-core write-miss / upgrade request (level)
//   miss_addr        per-core miss address, core i at [i*ADDR_W +: ADDR_W]
//   search_found     per-core snoop hit, sampled in RESP
//   block_dirty      per-core hit line is Modified, sampled in RESP
//   grant            one-hot bus owner, SNOOP through DONE
//   search           snoop strobe to every non-requesting core
//   addr_out         latched transaction address, 0 when idle
//   wback_dmem       one-hot dirty owner writes line to data memory
//   datasel          one-hot dirty owner drives bus data
//   invalidate       invalidate line at addr_out
//   done             one-cycle completion pulse to the requester
//   bus_busy         state is not IDLE
//   multi_owner_err  sticky: more than one dirty hit seen
module snoop_bus_n #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        read_miss,
    input  logic [NUM_CORES-1:0]        write_miss,
    input  logic [NUM_CORES*ADDR_W-1:0] miss_addr,
    input  logic [NUM_CORES-1:0]        search_found,
    input  logic [NUM_CORES-1:0]        block_dirty,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        search,
    output logic [ADDR_W-1:0]           addr_out,
    output logic [NUM_CORES-1:0]        wback_dmem,
    output logic [NUM_CORES-1:0]        datasel,
    output logic [NUM_CORES-1:0]        invalidate,
    output logic [NUM_CORES-1:0]        done,
    output logic                        bus_busy,
    output logic                        multi_owner_err
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_RESP, S_WBACK, S_INVAL, S_DONE
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_req_idx;
    logic                 r_is_write;
    logic [NUM_CORES-1:0] r_hits;

    logic [NUM_CORES-1:0] w_req;
    logic                 w_req_any;
    logic [IDX_W-1:0]     w_pick;
    logic [NUM_CORES-1:0] w_pick_oh;
    logic [ADDR_W-1:0]    w_pick_addr;
    logic [NUM_CORES-1:0] w_hit;
    logic [NUM_CORES-1:0] w_dirty;
    logic                 w_owner_any;
    logic [NUM_CORES-1:0] w_owner_oh;
    int                   w_dirty_cnt;

    // (base + off) modulo NUM_CORES, for off < NUM_CORES
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return IDX_W'(s);
    endfunction

    assign w_req = read_miss | write_miss;

    // Round-robin: first requester at or above r_ptr, wrapping around
    always_comb begin
        w_req_any = 1'b0;
        w_pick    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_req_any && w_req[wrap_add(r_ptr, i)]) begin
                w_req_any = 1'b1;
                w_pick    = wrap_add(r_ptr, i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            w_pick_oh[i] = (w_pick == IDX_W'(i));
        end
        w_pick_addr = miss_addr[w_pick*ADDR_W +: ADDR_W];
    end

    // grant holds the requester one-hot in RESP, so it masks the requester's own bit
    always_comb begin
        w_hit       = search_found & ~grant;
        w_dirty     = w_hit & block_dirty;
        w_owner_any = 1'b0;
        w_owner_oh  = '0;
        w_dirty_cnt = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_dirty[i]) begin
                w_dirty_cnt = w_dirty_cnt + 1;
                if (!w_owner_any) begin
                    w_owner_any   = 1'b1;
                    w_owner_oh[i] = 1'b1;
                end
            end
        end
    end

    // Outputs are loaded on the edge entering the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_req_idx       <= '0;
            r_is_write      <= 1'b0;
            r_hits          <= '0;
            grant           <= '0;
            search          <= '0;
            addr_out        <= '0;
            wback_dmem      <= '0;
            datasel         <= '0;
            invalidate      <= '0;
            done            <= '0;
            bus_busy        <= 1'b0;
            multi_owner_err <= 1'b0;
        end else begin
            search     <= '0;
            wback_dmem <= '0;
            datasel    <= '0;
            invalidate <= '0;
            done       <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state    <= S_SNOOP;
                        r_req_idx  <= w_pick;
                        r_is_write <= write_miss[w_pick];
                        grant      <= w_pick_oh;
                        search     <= ~w_pick_oh;
                        addr_out   <= w_pick_addr;
                        bus_busy   <= 1'b1;
                    end
                end
                S_SNOOP: r_state <= S_RESP;
                S_RESP: begin
                    r_hits <= w_hit;
                    if (w_dirty_cnt > 1) multi_owner_err <= 1'b1;
                    if (w_owner_any) begin
                        r_state    <= S_WBACK;
                        wback_dmem <= w_owner_oh;
                        datasel    <= w_owner_oh;
                    end else if (r_is_write && (|w_hit)) begin
                        r_state    <= S_INVAL;
                        invalidate <= w_hit;
                    end else begin
                        r_state <= S_DONE;
                        done    <= grant;
                    end
                end
                S_WBACK: begin
                    // Owner downgrades M->S on its own for a read
                    if (r_is_write) begin
                        r_state    <= S_INVAL;
                        invalidate <= r_hits;
                    end else begin
                        r_state <= S_DONE;
                        done    <= grant;
                    end
                end
                S_INVAL: begin
                    r_state <= S_DONE;
                    done    <= grant;
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_ptr    <= wrap_add(r_req_idx, 1);
                    grant    <= '0;
                    addr_out <= '0;
                    bus_busy <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_n.sv
// tb/tb_snoop_bus_n.sv - scoreboard bench for snoop_bus_n with four cores
module tb_snoop_bus_n;
    localparam int N  = 4;
    localparam int AW = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    read_miss, write_miss, search_found, block_dirty;
    logic [N*AW-1:0] miss_addr;
    logic [N-1:0]    grant, search, wback_dmem, datasel, invalidate, done;
    logic [AW-1:0]   addr_out;
    logic            bus_busy, multi_owner_err;

    snoop_bus_n #(.NUM_CORES(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .read_miss(read_miss), .write_miss(write_miss), .miss_addr(miss_addr),
        .search_found(search_found), .block_dirty(block_dirty),
        .grant(grant), .search(search), .addr_out(addr_out),
        .wback_dmem(wback_dmem), .datasel(datasel), .invalidate(invalidate),
        .done(done), .bus_busy(bus_busy), .multi_owner_err(multi_owner_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]  oh;
        logic [AW-1:0] addr;
        logic [N-1:0]  srch;
        logic [N-1:0]  wb;
        logic [N-1:0]  inv;
        int            lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic push(input logic [N-1:0] oh, input logic [AW-1:0] addr, input logic [N-1:0] srch,
                        input logic [N-1:0] wb, input logic [N-1:0] inv, input int lat);
        exp_t e;
        e.oh = oh; e.addr = addr; e.srch = srch; e.wb = wb; e.inv = inv; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Monitor: collect per-transaction activity, compare on each done pulse
    bit           in_txn = 1'b0;
    int           t_start, n_srch;
    logic [N-1:0] o_srch, o_wb, o_ds, o_inv;
    exp_t         me;

    always @(negedge clk) begin
        if (rst) begin
            in_txn = 1'b0;
        end else begin
            if (!in_txn && grant != '0) begin
                in_txn = 1'b1; t_start = cyc; n_srch = 0;
                o_srch = '0; o_wb = '0; o_ds = '0; o_inv = '0;
            end
            if (in_txn) begin
                o_srch |= search; o_wb |= wback_dmem; o_ds |= datasel; o_inv |= invalidate;
                if (search != '0) n_srch++;
            end
            if (done != '0) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {28'd0, done}, 32'd0);
                end else begin
                    me = exp_q.pop_front();
                    check("done", {28'd0, done}, {28'd0, me.oh});
                    check("grant", {28'd0, grant}, {28'd0, me.oh});
                    check("addr_out", {21'd0, addr_out}, {21'd0, me.addr});
                    check("bus_busy", {31'd0, bus_busy}, 32'd1);
                    check("search", {28'd0, o_srch}, {28'd0, me.srch});
                    check("search_cycles", n_srch, 1);
                    check("wback_dmem", {28'd0, o_wb}, {28'd0, me.wb});
                    check("datasel", {28'd0, o_ds}, {28'd0, me.wb});
                    check("invalidate", {28'd0, o_inv}, {28'd0, me.inv});
                    check("latency", cyc - t_start, me.lat);
                end
                in_txn = 1'b0;
            end
        end
    end

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (n_done < target) check("done_timeout", n_done, target);
    endtask

    task automatic wait_grant();
        int k;
        k = 0;
        while (grant == '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (grant == '0) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_req(input int c, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [N-1:0] f, input logic [N-1:0] d);
        read_miss  = '0; write_miss = '0; miss_addr = '0;
        read_miss[c]  = rd;
        write_miss[c] = wr;
        miss_addr[c*AW +: AW] = a;
        search_found = f;
        block_dirty  = d;
    endtask

    task automatic clear_req();
        read_miss = '0; write_miss = '0; search_found = '0; block_dirty = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, {28'd0, grant}, 32'd0);
        check({tag, "_strobes"}, {16'd0, search, wback_dmem, datasel, invalidate}, 32'd0);
        check({tag, "_done"}, {28'd0, done}, 32'd0);
        check({tag, "_addr_out"}, {21'd0, addr_out}, 32'd0);
        check({tag, "_busy_err"}, {30'd0, bus_busy, multi_owner_err}, 32'd0);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        read_miss = '0; write_miss = '0; miss_addr = '0; search_found = '0; block_dirty = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Round-robin: all cores request continuously from reset
        read_miss = 4'b1111;
        miss_addr = {11'h103, 11'h102, 11'h101, 11'h100};
        push(4'b0001, 11'h100, 4'b1110, 4'b0000, 4'b0000, 2);
        push(4'b0010, 11'h101, 4'b1101, 4'b0000, 4'b0000, 2);
        push(4'b0100, 11'h102, 4'b1011, 4'b0000, 4'b0000, 2);
        push(4'b1000, 11'h103, 4'b0111, 4'b0000, 4'b0000, 2);
        push(4'b0001, 11'h100, 4'b1110, 4'b0000, 4'b0000, 2);
        wait_done(4);
        @(posedge clk);
        @(posedge clk);
        #1 read_miss = '0;
        wait_done(5);

        // Clean read, core 2; request dropped once granted
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 11'h155, 4'b0000, 4'b0000);
        push(4'b0100, 11'h155, 4'b1011, 4'b0000, 4'b0000, 2);
        wait_grant();
        clear_req();
        wait_done(6);

        // Dirty read: core 0 reads, core 3 owns (own bit masked)
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 11'h2aa, 4'b1001, 4'b1001);
        push(4'b0001, 11'h2aa, 4'b1110, 4'b1000, 4'b0000, 3);
        wait_done(7);
        clear_req();

        // Dirty write: core 1 writes, cores 0 and 3 hit, core 3 dirty
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 11'h7ff, 4'b1001, 4'b1000);
        push(4'b0010, 11'h7ff, 4'b1101, 4'b1000, 4'b1001, 4);
        wait_done(8);
        clear_req();

        // Write with clean hits, own hit bit masked
        @(negedge clk);
        set_req(3, 1'b0, 1'b1, 11'h001, 4'b1011, 4'b0000);
        push(4'b1000, 11'h001, 4'b0111, 4'b0000, 4'b0011, 3);
        wait_done(9);
        clear_req();
        check("merr_clear", {31'd0, multi_owner_err}, 32'd0);

        // Two dirty hits: lowest index owns, error latches
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 11'h0ab, 4'b0110, 4'b0110);
        push(4'b0001, 11'h0ab, 4'b1110, 4'b0010, 4'b0000, 3);
        wait_done(10);
        clear_req();
        check("merr_set", {31'd0, multi_owner_err}, 32'd1);

        // Read and write both set: handled as a write
        @(negedge clk);
        set_req(2, 1'b1, 1'b1, 11'h3c3, 4'b0001, 4'b0000);
        push(4'b0100, 11'h3c3, 4'b1011, 4'b0000, 4'b0001, 3);
        wait_done(11);
        clear_req();

        // Reset during WBACK aborts with no done pulse
        @(negedge clk);
        set_req(2, 1'b0, 1'b1, 11'h444, 4'b0001, 4'b0001);
        begin
            int k;
            k = 0;
            while (wback_dmem == '0 && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("abort_wback", {28'd0, wback_dmem}, 32'h1);
        base = n_done;
        rst = 1'b1;
        #1 check_all_zero("async_rst");
        clear_req();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_done_after_abort", n_done, base);

        // After reset ptr is 0, so core 1 wins over core 3
        read_miss = 4'b1010;
        miss_addr = {11'h033, 11'h000, 11'h011, 11'h000};
        push(4'b0010, 11'h011, 4'b1101, 4'b0000, 4'b0000, 2);
        push(4'b1000, 11'h033, 4'b0111, 4'b0000, 4'b0000, 2);
        wait_done(base + 1);
        read_miss = 4'b1000;
        wait_done(base + 2);
        clear_req();
        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("idle_addr_out", {21'd0, addr_out}, 32'd0);
        check("idle_busy", {31'd0, bus_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/snoop_bus_n.md
# snoop_bus_n

Parametrised snooping coherence bus for an N-core MSI system. It arbitrates cache-miss requests from NUM_CORES cores round-robin and broadcasts the winning miss address to every other core as a snoop. It then sequences dirty-owner writeback, invalidation and completion before handing the bus to the next requester. It sits between the per-core cache controllers and data memory, and supersedes the fixed two-core bus.

## Interface

Clocking: one clock; reset is asynchronous and active-high.

Parameters
- NUM_CORES, 2: number of cores, legal range 1..16.
- ADDR_W, 11: block address width.

Ports
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_miss  in  NUM_CORES  per-core read-miss request (level).
- write_miss  in  NUM_CORES  per-core write-miss / upgrade request (level).
- miss_addr  in  NUM_CORES*ADDR_W  per-core miss address; core i occupies bits [i*ADDR_W +: ADDR_W].
- search_found  in  NUM_CORES  per-core snoop hit, valid in RESP.
- block_dirty  in  NUM_CORES  per-core hit line is Modified, valid in RESP.
- grant  out  NUM_CORES  one-hot; current bus owner.
- search  out  NUM_CORES  snoop strobe to every non-requesting core.
- addr_out  out  ADDR_W  latched transaction address.
- wback_dmem  out  NUM_CORES  one-hot; dirty owner writes the line to data memory.
- datasel  out  NUM_CORES  one-hot; dirty owner drives bus data to the requester.
- invalidate  out  NUM_CORES  invalidate the line at addr_out.
- done  out  NUM_CORES  one-cycle completion pulse to the requester.
- bus_busy  out  1  state is not IDLE.
- multi_owner_err  out  1  sticky; more than one dirty hit was seen.

## Operation

- The request vector is req[i] = read_miss[i] | write_miss[i]. If both bits are set for a core, the request is treated as a write.
- FSM states: IDLE, SNOOP, RESP, WBACK, INVAL, DONE.
- IDLE
  - Pick the first set req[i] searching from ptr upward with wrap-around.
  - Latch the requester index, miss_addr[i] and op (read or write); go to SNOOP.
  - Requests are sampled only in IDLE.
- SNOOP: search[j]=1 for all j≠requester for exactly one cycle; go to RESP.
- RESP: sample search_found and block_dirty.
  - Mask out the requester's own bit.
  - owner = lowest-index j with found & dirty.
  - If more than one dirty hit is seen, set multi_owner_err; it stays set until rst.
  - Next state: owner exists → WBACK; else write with any hit → INVAL; else → DONE.
- WBACK
  - wback_dmem[owner]=1 and datasel[owner]=1 for one cycle.
  - For a write, go to INVAL; for a read, go to DONE. The owner downgrades M→S itself.
- INVAL: invalidate[j]=1 for one cycle for every j≠requester with a sampled hit, including the owner; go to DONE.
- DONE
  - done[requester]=1 for one cycle.
  - ptr ← requester+1 (NUM_CORES−1 wraps to 0).
  - Go to IDLE.
- grant[requester] is high from SNOOP through DONE inclusive. addr_out holds the latched address over the same span and is 0 in IDLE.
- A requester that drops its request mid-transaction is ignored; the transaction completes.
- A requester that still holds its request in the IDLE cycle after DONE is re-arbitrated at lowest priority.
- NUM_CORES=1: no snoop targets, so the sequence is SNOOP→RESP→DONE.

## Timing

- Reset (asynchronous, immediate):
  - State IDLE, ptr=0.
  - All outputs 0: grant, search, addr_out, wback_dmem, datasel, invalidate, done, bus_busy, multi_owner_err.
- Reset asserted mid-transaction aborts the transaction; no done pulse is issued.
- All outputs are registered or decoded from the state register only; there are no combinational input→output paths.
- Latency from the IDLE cycle that samples the request (cycle 0) to done:
  - clean read or write, no hits: cycle 3;
  - write with clean hits: cycle 4;
  - read with dirty owner: cycle 4;
  - write with dirty owner: cycle 5.
- Back-to-back: the next arbitration happens in the IDLE cycle immediately after DONE. Minimum bus turnaround is 4 cycles.

## Test plan

- Clean read, NUM_CORES=4:
  - Stimulus: core 2 read_miss, addr 0x155; no hits.
  - Response: search=4'b1011 in cycle 1; done[2] in cycle 3; addr_out=0x155 during cycles 1–3; no wback or invalidate.
- Dirty read:
  - Stimulus: core 0 read; core 3 found and dirty.
  - Response: cycle 3 wback_dmem=4'b1000 and datasel=4'b1000; done[0] in cycle 4; invalidate stays 0.
- Dirty write:
  - Stimulus: core 1 write; cores 0 and 3 hit, core 3 dirty.
  - Response: WBACK on core 3 in cycle 3; invalidate=4'b1001 in cycle 4; done[1] in cycle 5.
- Round-robin fairness:
  - Stimulus: all four cores request continuously from reset.
  - Response: grant order 0,1,2,3,0; ptr wraps from 3 to 0.
- Error and reset:
  - Stimulus: two dirty hits in RESP; then assert rst during a later WBACK.
  - Response: multi_owner_err=1 after RESP; on rst all outputs are 0 immediately and no done pulse occurs.
